// File: rtl/wb_host_master.sv
// wb_host_master: Wishbone classic-cycle initiator fed by a small command FIFO.
//
// Commands (read/write) are queued, then executed one at a time as single
// Wishbone cycles. Each command yields exactly one response, held until
// consumed. Only one cycle is ever outstanding.
//
// Optional feature (macro WBM_TIMEOUT_EN): abort a bus cycle after
// TIMEOUT_CYCLES cycles without ack, returning rsp_err = 1 and all-ones data.
// Without the macro the bus waits indefinitely and rsp_err is tied to 0.
//
// Ports:
//   wb_clk_i, wb_rst_i           clock, asynchronous active-high reset
//   cmd_valid/cmd_ready          command handshake (cmd_ready = !full)
//   cmd_we/adr/dat/sel           command payload
//   rsp_valid/rsp_ready          response handshake
//   rsp_dat, rsp_err             read data (0 for writes), timeout flag
//   wbm_cyc_o/stb_o/we_o/sel_o   Wishbone master controls
//   wbm_adr_o, wbm_dat_o         Wishbone address / write data
//   wbm_dat_i, wbm_ack_i         Wishbone read data / acknowledge

module wb_host_master #(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_adr,
    input  logic [31:0] cmd_dat,
    input  logic [3:0]  cmd_sel,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_dat,
    output logic        rsp_err,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i
);

    localparam int unsigned PtrW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned EntryW = 69;  // {we, sel[3:0], adr[31:0], dat[31:0]}

    typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

    state_e state_q, state_d;

    // ---------------------------------------------------------------------
    // Command FIFO
    // ---------------------------------------------------------------------
    logic [EntryW-1:0] mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]     count_q, count_d;
    logic              full, empty, push, pop;
    logic [EntryW-1:0] head;

    assign full      = (count_q == (PtrW + 1)'(FIFO_DEPTH));
    assign empty     = (count_q == '0);
    assign cmd_ready = !full;
    // Full refuses a push even when a pop happens in the same cycle.
    assign push      = cmd_valid && !full;
    assign head      = mem_q[rd_ptr_q];

    always_ff @(posedge wb_clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {cmd_we, cmd_sel, cmd_adr, cmd_dat};
        end
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // ---------------------------------------------------------------------
    // Optional bus timeout
    // ---------------------------------------------------------------------
    logic tmo_hit;

`ifdef WBM_TIMEOUT_EN
    logic [15:0] tmo_cnt_q;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            tmo_cnt_q <= '0;
        end else if (pop) begin
            tmo_cnt_q <= '0;
        end else if (state_q == StBus) begin
            tmo_cnt_q <= tmo_cnt_q + 16'd1;
        end
    end

    // Counter holds the number of completed BUS cycles, so this fires in the
    // TIMEOUT_CYCLES-th BUS cycle.
    assign tmo_hit = (state_q == StBus) && (tmo_cnt_q == 16'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    // ---------------------------------------------------------------------
    // FSM: state register / next state / outputs
    // ---------------------------------------------------------------------
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (!empty) state_d = StBus;
            StBus:   if (wbm_ack_i || tmo_hit) state_d = StResp;
            StResp:  if (rsp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Strobes decode straight from the state so reset drops them asynchronously.
    always_comb begin
        wbm_cyc_o = (state_q == StBus);
        wbm_stb_o = (state_q == StBus);
        rsp_valid = (state_q == StResp);
        pop       = (state_q == StIdle) && !empty;
    end

    // ---------------------------------------------------------------------
    // Bus request and response registers
    // ---------------------------------------------------------------------
    logic        wbm_we_q;
    logic [3:0]  wbm_sel_q;
    logic [31:0] wbm_adr_q, wbm_dat_q, rsp_dat_q;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wbm_we_q  <= 1'b0;
            wbm_sel_q <= '0;
            wbm_adr_q <= '0;
            wbm_dat_q <= '0;
            rsp_dat_q <= '0;
        end else begin
            if (pop) begin
                {wbm_we_q, wbm_sel_q, wbm_adr_q, wbm_dat_q} <= head;
            end
            // Ack beats a coincident terminal count.
            if (state_q == StBus && wbm_ack_i) begin
                rsp_dat_q <= wbm_we_q ? 32'h0 : wbm_dat_i;
            end else if (tmo_hit) begin
                rsp_dat_q <= 32'hFFFF_FFFF;
            end
        end
    end

`ifdef WBM_TIMEOUT_EN
    logic rsp_err_q;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            rsp_err_q <= 1'b0;
        end else if (state_q == StBus && wbm_ack_i) begin
            rsp_err_q <= 1'b0;
        end else if (tmo_hit) begin
            rsp_err_q <= 1'b1;
        end
    end

    assign rsp_err = rsp_err_q;
`else
    assign rsp_err = 1'b0;
`endif

    assign wbm_we_o  = wbm_we_q;
    assign wbm_sel_o = wbm_sel_q;
    assign wbm_adr_o = wbm_adr_q;
    assign wbm_dat_o = wbm_dat_q;
    assign rsp_dat   = rsp_dat_q;

endmodule

// File: tb/tb_wb_host_master.sv
// Self-checking bench for wb_host_master: a wait-state-programmable slave,
// a monitor recording bus beats and consumed responses, and per-scenario tasks.
`timescale 1ns/1ps

module tb_wb_host_master;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_adr, cmd_dat;
    logic [3:0]  cmd_sel;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_dat;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
    logic        wbm_ack_i;

    int checks = 0;
    int errors = 0;

    logic [32:0] exp_rsp_q[$];
    logic [32:0] obs_rsp_q[$];
    logic [68:0] exp_bus_q[$];
    logic [68:0] obs_bus_q[$];

    int          slv_wait  = 0;
    logic        slv_noack = 1'b0;
    logic [31:0] slv_xor   = 32'h0;
    int          slv_cnt;
    int          cyc_cnt   = 0;

    wb_host_master #(
        .FIFO_DEPTH     (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_i  (wb_rst_i),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_adr   (cmd_adr),
        .cmd_dat   (cmd_dat),
        .cmd_sel   (cmd_sel),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_dat   (rsp_dat),
        .rsp_err   (rsp_err),
        .wbm_cyc_o (wbm_cyc_o),
        .wbm_stb_o (wbm_stb_o),
        .wbm_we_o  (wbm_we_o),
        .wbm_sel_o (wbm_sel_o),
        .wbm_adr_o (wbm_adr_o),
        .wbm_dat_o (wbm_dat_o),
        .wbm_dat_i (wbm_dat_i),
        .wbm_ack_i (wbm_ack_i)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // Slave: acks after slv_wait wait states; read data derived from address.
    always @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) slv_cnt <= 0;
        else if (wbm_cyc_o && wbm_stb_o && !wbm_ack_i) slv_cnt <= slv_cnt + 1;
        else slv_cnt <= 0;
    end
    assign wbm_ack_i = wbm_cyc_o && wbm_stb_o && !slv_noack && (slv_cnt == slv_wait);
    assign wbm_dat_i = wbm_adr_o ^ slv_xor;

    // Monitor on the falling edge, away from the active edge.
    always @(negedge wb_clk_i) begin
        if (!wb_rst_i) begin
            if (wbm_cyc_o) cyc_cnt <= cyc_cnt + 1;
            if (wbm_cyc_o && wbm_stb_o && wbm_ack_i)
                obs_bus_q.push_back({wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o});
            if (rsp_valid && rsp_ready) obs_rsp_q.push_back({rsp_err, rsp_dat});
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1);
    end

    // Drives one command for one edge and records what it should produce.
    task automatic push_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_dat   = dat;
        cmd_sel   = sel;
        if (!slv_noack) exp_bus_q.push_back({we, sel, adr, dat});
        exp_rsp_q.push_back(slv_noack ? {1'b1, 32'hFFFF_FFFF} :
                            (we ? 33'h0 : {1'b0, adr ^ slv_xor}));
        @(posedge wb_clk_i); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready);
        end
        checks++;
        if ({wbm_cyc_o, wbm_stb_o, wbm_we_o} !== 3'b000) begin
            errors++; $display("FAIL reset_strobes: got %b want 000", {wbm_cyc_o, wbm_stb_o, wbm_we_o});
        end
        checks++;
        if ({wbm_sel_o, wbm_adr_o, wbm_dat_o} !== 68'h0) begin
            errors++; $display("FAIL reset_bus_regs: got %h want 0", {wbm_sel_o, wbm_adr_o, wbm_dat_o});
        end
        checks++;
        if ({rsp_valid, rsp_err, rsp_dat} !== 34'h0) begin
            errors++; $display("FAIL reset_rsp: got %h want 0", {rsp_valid, rsp_err, rsp_dat});
        end
    endtask

    task automatic test_write_zero_wait();
        logic [32:0] e, o;
        logic [68:0] eb, ob;
        rsp_ready = 1'b1; slv_wait = 0; slv_xor = 32'h5555_0000;
        push_cmd(1'b1, 32'h3000_0004, 32'hA5A5_1234, 4'hF);
        checks++;
        if (wbm_cyc_o !== 1'b0) begin
            errors++; $display("FAIL write_idle_cyc: got %b want 0", wbm_cyc_o);
        end
        @(posedge wb_clk_i); #1;
        checks++;
        if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o} !==
            {3'b111, 4'hF, 32'h3000_0004, 32'hA5A5_1234}) begin
            errors++; $display("FAIL write_bus: got cyc=%b stb=%b we=%b sel=%h adr=%h dat=%h want 1 1 1 f 30000004 a5a51234",
                               wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o);
        end
        @(posedge wb_clk_i); #1;
        checks++;
        if ({wbm_cyc_o, wbm_stb_o, rsp_valid, rsp_err, rsp_dat} !== {4'b0010, 32'h0}) begin
            errors++; $display("FAIL write_rsp_cycle: got cyc=%b stb=%b vld=%b err=%b dat=%h want 0 0 1 0 0",
                               wbm_cyc_o, wbm_stb_o, rsp_valid, rsp_err, rsp_dat);
        end
        @(posedge wb_clk_i); #1;
        checks++;
        if ({rsp_valid, wbm_adr_o} !== {1'b0, 32'h3000_0004}) begin
            errors++; $display("FAIL write_after: got vld=%b adr=%h want 0 30000004", rsp_valid, wbm_adr_o);
        end
        while (exp_rsp_q.size() > 0 && obs_rsp_q.size() > 0) begin
            e = exp_rsp_q.pop_front(); o = obs_rsp_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL write_sb_rsp: got %h want %h", o, e); end
        end
        while (exp_bus_q.size() > 0 && obs_bus_q.size() > 0) begin
            eb = exp_bus_q.pop_front(); ob = obs_bus_q.pop_front(); checks++;
            if (ob !== eb) begin errors++; $display("FAIL write_sb_bus: got %h want %h", ob, eb); end
        end
    endtask

    task automatic test_read_wait(input int waits, input int want_cyc, input string nm);
        int c0, guard;
        logic [32:0] e, o;
        logic [68:0] eb, ob;
        rsp_ready = 1'b1; slv_wait = waits; slv_xor = 32'h3000_0010 ^ 32'hDEAD_0001;
        c0 = cyc_cnt;
        push_cmd(1'b0, 32'h3000_0010, 32'h0, 4'hF);
        guard = 0;
        while (obs_rsp_q.size() < 1 && guard < 100) begin @(posedge wb_clk_i); #1; guard++; end
        checks++;
        if (obs_rsp_q.size() < 1) begin
            errors++; $display("FAIL %s_no_rsp: got 0 responses want 1", nm);
        end
        checks++;
        if (cyc_cnt - c0 != want_cyc) begin
            errors++; $display("FAIL %s_cyc_len: got %0d want %0d", nm, cyc_cnt - c0, want_cyc);
        end
        while (exp_rsp_q.size() > 0 && obs_rsp_q.size() > 0) begin
            e = exp_rsp_q.pop_front(); o = obs_rsp_q.pop_front(); checks++;
            if (o !== {1'b0, 32'hDEAD_0001} || o !== e) begin
                errors++; $display("FAIL %s_rsp: got %h want %h", nm, o, {1'b0, 32'hDEAD_0001});
            end
        end
        while (exp_bus_q.size() > 0 && obs_bus_q.size() > 0) begin
            eb = exp_bus_q.pop_front(); ob = obs_bus_q.pop_front(); checks++;
            if (ob !== eb) begin errors++; $display("FAIL %s_bus: got %h want %h", nm, ob, eb); end
        end
    endtask

    task automatic test_rsp_hold();
        int c0, guard;
        logic [31:0] hold_exp;
        logic [32:0] e, o;
        rsp_ready = 1'b0; slv_wait = 0; slv_xor = 32'h0F0F_0000;
        hold_exp = 32'h3000_0020 ^ 32'h0F0F_0000;
        push_cmd(1'b0, 32'h3000_0020, 32'h0, 4'hF);
        push_cmd(1'b1, 32'h3000_0024, 32'h1234_5678, 4'h3);
        guard = 0;
        while (!rsp_valid && guard < 20) begin @(posedge wb_clk_i); #1; guard++; end
        c0 = cyc_cnt;
        for (int i = 0; i < 10; i++) begin
            @(posedge wb_clk_i); #1;
            checks++;
            if ({rsp_valid, rsp_dat, wbm_cyc_o} !== {1'b1, hold_exp, 1'b0}) begin
                errors++; $display("FAIL hold_cycle%0d: got vld=%b dat=%h cyc=%b want 1 %h 0",
                                   i, rsp_valid, rsp_dat, wbm_cyc_o, hold_exp);
            end
        end
        checks++;
        if (cyc_cnt != c0) begin
            errors++; $display("FAIL hold_no_cyc: got %0d cyc cycles want 0", cyc_cnt - c0);
        end
        rsp_ready = 1'b1;
        guard = 0;
        while (obs_rsp_q.size() < 2 && guard < 50) begin @(posedge wb_clk_i); #1; guard++; end
        checks++;
        if (obs_rsp_q.size() != 2) begin
            errors++; $display("FAIL hold_count: got %0d responses want 2", obs_rsp_q.size());
        end
        while (exp_rsp_q.size() > 0 && obs_rsp_q.size() > 0) begin
            e = exp_rsp_q.pop_front(); o = obs_rsp_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL hold_sb_rsp: got %h want %h", o, e); end
        end
        exp_bus_q.delete(); obs_bus_q.delete();
    endtask

    task automatic test_fifo_full();
        int guard;
        logic [32:0] e, o;
        logic [68:0] eb, ob;
        rsp_ready = 1'b0; slv_wait = 0; slv_xor = 32'h1111_0000;
        for (int i = 0; i < 5; i++) begin
            push_cmd(i[0], 32'h3000_0100 + 32'(i * 4), 32'hC0DE_0000 + 32'(i), 4'(i + 1));
            checks++;
            if (cmd_ready !== (i < 4)) begin
                errors++; $display("FAIL fifo_ready_push%0d: got %b want %b", i, cmd_ready, i < 4);
            end
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge wb_clk_i); #1;
            checks++;
            if ({cmd_ready, rsp_valid} !== 2'b01) begin
                errors++; $display("FAIL fifo_stalled%0d: got rdy=%b vld=%b want 0 1", i, cmd_ready, rsp_valid);
            end
        end
        rsp_ready = 1'b1;
        @(posedge wb_clk_i); #1;
        // Still full while idle: this push coincides with the pop and must be refused.
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h3000_0200; cmd_dat = 32'hBAD0_0000;
        cmd_sel = 4'hF;
        @(posedge wb_clk_i); #1;
        cmd_valid = 1'b0;
        checks++;
        if ({cmd_ready, wbm_cyc_o, wbm_adr_o} !== {2'b11, 32'h3000_0104}) begin
            errors++; $display("FAIL fifo_pop: got rdy=%b cyc=%b adr=%h want 1 1 30000104",
                               cmd_ready, wbm_cyc_o, wbm_adr_o);
        end
        guard = 0;
        while (obs_rsp_q.size() < 5 && guard < 100) begin @(posedge wb_clk_i); #1; guard++; end
        repeat (10) @(posedge wb_clk_i);
        #1;
        checks++;
        if (obs_rsp_q.size() != exp_rsp_q.size()) begin
            errors++; $display("FAIL fifo_count: got %0d responses want %0d", obs_rsp_q.size(), exp_rsp_q.size());
        end
        while (exp_rsp_q.size() > 0 && obs_rsp_q.size() > 0) begin
            e = exp_rsp_q.pop_front(); o = obs_rsp_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL fifo_sb_rsp: got %h want %h", o, e); end
        end
        while (exp_bus_q.size() > 0 && obs_bus_q.size() > 0) begin
            eb = exp_bus_q.pop_front(); ob = obs_bus_q.pop_front(); checks++;
            if (ob !== eb) begin errors++; $display("FAIL fifo_sb_bus: got %h want %h", ob, eb); end
        end
        obs_bus_q.delete();
    endtask

`ifdef WBM_TIMEOUT_EN
    task automatic test_timeout();
        int c0, guard;
        logic [32:0] e, o;
        rsp_ready = 1'b1; slv_xor = 32'h2222_0000;
        for (int k = 0; k < 3; k++) begin
            // k=0: no ack; k=1: ack on terminal count; k=2: normal write after
            slv_noack = (k == 0);
            slv_wait  = (k == 1) ? 7 : 0;
            c0 = cyc_cnt;
            push_cmd(k == 2, 32'h3000_0030 + 32'(k * 4), 32'h7777_0000, 4'hF);
            guard = 0;
            while (obs_rsp_q.size() < 1 && guard < 100) begin @(posedge wb_clk_i); #1; guard++; end
            checks++;
            if (cyc_cnt - c0 != ((k == 2) ? 1 : 8)) begin
                errors++; $display("FAIL tmo_cyc_len%0d: got %0d want %0d", k, cyc_cnt - c0, (k == 2) ? 1 : 8);
            end
            while (exp_rsp_q.size() > 0 && obs_rsp_q.size() > 0) begin
                e = exp_rsp_q.pop_front(); o = obs_rsp_q.pop_front(); checks++;
                if (o !== e) begin errors++; $display("FAIL tmo_rsp%0d: got %h want %h", k, o, e); end
            end
        end
        slv_noack = 1'b0;
        exp_bus_q.delete(); obs_bus_q.delete();
    endtask
`endif

    task automatic test_reset_mid();
        int c0, n0;
        rsp_ready = 1'b1; slv_wait = 20; slv_xor = 32'h0;
        push_cmd(1'b0, 32'h3000_0300, 32'h0, 4'hF);
        push_cmd(1'b1, 32'h3000_0304, 32'h1, 4'hF);
        push_cmd(1'b1, 32'h3000_0308, 32'h2, 4'hF);
        checks++;
        if (wbm_cyc_o !== 1'b1) begin
            errors++; $display("FAIL rstmid_in_bus: got cyc=%b want 1", wbm_cyc_o);
        end
        wb_rst_i = 1'b1;
        #1;
        checks++;
        if ({wbm_cyc_o, wbm_stb_o, cmd_ready, rsp_valid} !== 4'b0010) begin
            errors++; $display("FAIL rstmid_async: got cyc=%b stb=%b rdy=%b vld=%b want 0 0 1 0",
                               wbm_cyc_o, wbm_stb_o, cmd_ready, rsp_valid);
        end
        exp_rsp_q.delete(); exp_bus_q.delete();
        @(posedge wb_clk_i); #1;
        wb_rst_i = 1'b0;
        c0 = cyc_cnt; n0 = obs_rsp_q.size();
        repeat (10) @(posedge wb_clk_i);
        #1;
        checks++;
        if (cyc_cnt != c0 || obs_rsp_q.size() != n0 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL rstmid_discard: got cyc=%0d rsp=%0d vld=%b want 0 0 0",
                               cyc_cnt - c0, obs_rsp_q.size() - n0, rsp_valid);
        end
    endtask

    initial begin
        wb_rst_i = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0;
        cmd_sel = '0; rsp_ready = 1'b0;
        repeat (2) @(posedge wb_clk_i);
        #1;
        wb_rst_i = 1'b0;
        test_reset();
        test_write_zero_wait();
        test_read_wait(3, 4, "read_wait3");
        test_rsp_hold();
        test_fifo_full();
`ifdef WBM_TIMEOUT_EN
        test_timeout();
`else
        test_read_wait(12, 13, "read_wait12");
`endif
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
